// File: rtl/ck1_spi_pkg.sv
// Shared constants and types for the ck1 SPI mode-0 target.
package ck1_spi_pkg;

  // Mode 0: sck idles low, data sampled on the rising edge.
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  // Byte shifted out when nothing is queued at a byte boundary.
  localparam logic [7:0] IDLE_FILL_DEF = 8'hff;

  // Bit counter width (counts 0..7 within a byte).
  localparam int CNT_W = 3;

  // Synchronized pin bundle: index of each pin and its idle level.
  localparam int NUM_PINS = 3;
  localparam int PIN_SS   = 0;
  localparam int PIN_SCK  = 1;
  localparam int PIN_MOSI = 2;
  localparam logic [NUM_PINS-1:0] PIN_IDLE = {1'b1, CPOL, 1'b1};

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // Byte loaded into the TX shifter at a byte boundary.
  function automatic logic [7:0] tx_reload(input logic       full,
                                           input logic [7:0] hold,
                                           input logic [7:0] fill);
    return full ? hold : fill;
  endfunction

endpackage

// File: rtl/ck1_spi_target_if.sv
// SPI pins plus byte-level RX/TX handshake toward the register front-end.
interface ck1_spi_target_if;

  logic       spi_ss;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;
  logic [7:0] tx_data;
  logic       tx_data_vld;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_data_vld;
  logic       rx_ack;
  logic       rx_overrun;
  logic       overrun_clr;
  logic       selected;

  // Target side (the DUT).
  modport slave (
    input  spi_ss, spi_sck, spi_mosi, tx_data, tx_data_vld, rx_ack, overrun_clr,
    output spi_miso, tx_ready, rx_data, rx_data_vld, rx_overrun, selected
  );

  // Host / SPI master side.
  modport master (
    output spi_ss, spi_sck, spi_mosi, tx_data, tx_data_vld, rx_ack, overrun_clr,
    input  spi_miso, tx_ready, rx_data, rx_data_vld, rx_overrun, selected
  );

endinterface

// File: rtl/ck1_spi_sync.sv
// Multi-flop synchronizer for one asynchronous pin, followed by a history
// flop used to produce single-cycle rise/fall pulses. SYNC_STAGES is 2..3.
module ck1_spi_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Synchronizer chain and history flop reset to the pin's idle level so
  // no edge is reported when reset is released on an idle bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o =  q_o & ~hist_q;
  assign fall_o = ~q_o &  hist_q;

endmodule

// File: rtl/ck1_spi_target.sv
// SPI mode-0 target. Pins are oversampled in the clk domain; received bytes
// are handed out through rx_data/rx_data_vld/rx_ack and transmit bytes are
// queued in a single holding register through tx_data/tx_data_vld/tx_ready.
module ck1_spi_target
  import ck1_spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_FILL   = IDLE_FILL_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  ck1_spi_target_if.slave    bus
);

  // ---------------------------------------------------------------------
  // Pin synchronization
  // ---------------------------------------------------------------------
  logic [NUM_PINS-1:0] pin_raw, pin_q, pin_rise, pin_fall;

  assign pin_raw = {bus.spi_mosi, bus.spi_sck, bus.spi_ss};

  for (genvar g = 0; g < NUM_PINS; g++) begin : g_sync
    ck1_spi_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .RST_VAL     (PIN_IDLE[g])
    ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d_i     (pin_raw[g]),
      .q_o     (pin_q[g]),
      .rise_o  (pin_rise[g]),
      .fall_o  (pin_fall[g])
    );
  end

  logic ss_rise, ss_fall, sck_rise, sck_fall, mosi_s;
  assign ss_rise  = pin_rise[PIN_SS];
  assign ss_fall  = pin_fall[PIN_SS];
  assign sck_rise = pin_rise[PIN_SCK];
  assign sck_fall = pin_fall[PIN_SCK];
  assign mosi_s   = pin_q[PIN_MOSI];

  // Only edge information is needed for sck, only the level for mosi.
  logic unused_pins;
  assign unused_pins = ^{pin_q[PIN_SCK], pin_rise[PIN_MOSI], pin_fall[PIN_MOSI]};

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  state_e state_q, state_d;
  logic   start, stop, rx_step, tx_step;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state: select falling opens a frame, select rising closes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (ss_fall) state_d = ST_ACTIVE;
      ST_ACTIVE: if (ss_rise) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: sck edges only count while selected, and a deselect in
  // the same cycle as an sck edge wins over that edge.
  always_comb begin
    start   = 1'b0;
    stop    = 1'b0;
    rx_step = 1'b0;
    tx_step = 1'b0;
    case (state_q)
      ST_IDLE:   start = ss_fall;
      ST_ACTIVE: begin
        stop    = ss_rise;
        rx_step = sck_rise & ~ss_rise;
        tx_step = sck_fall & ~ss_rise;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_vld_q, rx_vld_d;
  logic             ovr_q, ovr_d;

  logic       byte_done, reload;
  logic [7:0] rx_byte;

  assign byte_done = rx_step & (&bit_cnt_q);
  assign reload    = start | byte_done;
  assign rx_byte   = {rx_shift_q[6:0], mosi_s};

  // Next-state logic for counters, shifters, holding register and flags.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_vld_d    = rx_vld_q;
    ovr_d       = ovr_q;

    // Frame boundaries realign the bit counter; a partial byte is dropped.
    if (start || stop)  bit_cnt_d = '0;
    else if (rx_step)   bit_cnt_d = bit_cnt_q + CNT_W'(1);

    if (rx_step) rx_shift_d = rx_byte;

    // Reload at frame start and at every byte boundary so the next MSB is
    // on miso before the master's next rising edge. The falling edge right
    // after a boundary must not shift, or that MSB would be lost.
    if (reload)
      tx_shift_d = tx_reload(hold_full_q, hold_q, IDLE_FILL);
    else if (tx_step && (bit_cnt_q != '0))
      tx_shift_d = {tx_shift_q[6:0], 1'b1};

    // A write is accepted when the holder is empty or is being drained in
    // this very cycle; otherwise it is dropped.
    if (bus.tx_data_vld && (!hold_full_q || reload)) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end else if (reload) begin
      hold_full_d = 1'b0;
    end

    // A completed byte always overwrites; ack in the same cycle counts as
    // consuming the old byte, so no overrun then.
    if (byte_done) begin
      rx_data_d = rx_byte;
      rx_vld_d  = 1'b1;
    end else if (bus.rx_ack) begin
      rx_vld_d  = 1'b0;
    end

    if (byte_done && rx_vld_q && !bus.rx_ack) ovr_d = 1'b1;
    else if (bus.overrun_clr)                 ovr_d = 1'b0;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= IDLE_FILL;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_vld_q    <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_vld_q    <= rx_vld_d;
      ovr_q       <= ovr_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.spi_miso    = (state_q == ST_ACTIVE) ? tx_shift_q[7] : 1'b1;
  assign bus.tx_ready    = ~hold_full_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_data_vld = rx_vld_q;
  assign bus.rx_overrun  = ovr_q;
  assign bus.selected    = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_ck1_spi_target.sv
// Bench for ck1_spi_target: bit-banged SPI master, with scoreboards for
// received bytes (rx_data) and bytes seen by the master on miso.
module tb_ck1_spi_target;

  localparam int SYNC  = 2;
  localparam int HALF  = 8;   // clk cycles per sck half period
  localparam int SETUP = 8;   // clk cycles from ss fall to first sck activity

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ck1_spi_target_if bus();

  ck1_spi_target #(
    .SYNC_STAGES (SYNC),
    .IDLE_FILL   (8'hff)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];
  bit         ack_en = 1'b1;

  logic       rm_vld_prev = 1'b0;
  logic [7:0] rm_data_prev = 8'h00;
  logic [7:0] mm_sh = 8'h00;
  int         mm_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RX monitor: every newly presented byte is popped from the scoreboard.
  initial begin : rx_mon
    logic [7:0] e;
    bus.rx_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.rx_ack) begin
        bus.rx_ack = 1'b0;
      end else if (bus.rx_data_vld) begin
        if (!rm_vld_prev || bus.rx_data != rm_data_prev) begin
          if (exp_rx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: got %0h expected none", bus.rx_data);
          end else begin
            e = exp_rx.pop_front();
            check("rx_data", bus.rx_data, e);
          end
        end
        if (ack_en) bus.rx_ack = 1'b1;
      end
      rm_vld_prev  = bus.rx_data_vld;
      rm_data_prev = bus.rx_data;
    end
  end

  // MISO monitor: master-side sampling on sck rise; deselect drops partials.
  initial begin : miso_mon
    logic [7:0] e;
    forever begin
      @(posedge bus.spi_sck or posedge bus.spi_ss);
      if (bus.spi_ss === 1'b1) begin
        mm_n = 0;
      end else begin
        mm_sh = {mm_sh[6:0], bus.spi_miso};
        mm_n++;
        if (mm_n == 8) begin
          mm_n = 0;
          if (exp_miso.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL miso_unexpected: got %0h expected none", mm_sh);
          end else begin
            e = exp_miso.pop_front();
            check("miso_byte", mm_sh, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic bit_rise(input logic b);
    @(negedge clk);
    bus.spi_mosi = b;
    repeat (HALF) @(negedge clk);
    bus.spi_sck = 1'b1;
  endtask

  task automatic bit_fall();
    repeat (HALF) @(negedge clk);
    bus.spi_sck = 1'b0;
  endtask

  task automatic xfer_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      bit_rise(b[i]);
      bit_fall();
    end
  endtask

  task automatic xfer(input logic [7:0] b);
    xfer_bits(b, 8);
  endtask

  task automatic ss_low();
    @(negedge clk);
    bus.spi_ss = 1'b0;
    repeat (SETUP) @(negedge clk);
  endtask

  task automatic ss_high();
    repeat (HALF) @(negedge clk);
    bus.spi_ss = 1'b1;
    repeat (SETUP) @(negedge clk);
  endtask

  task automatic tx_write(input logic [7:0] b);
    @(negedge clk);
    bus.tx_data     = b;
    bus.tx_data_vld = 1'b1;
    @(negedge clk);
    bus.tx_data_vld = 1'b0;
  endtask

  initial begin : main
    int n;
    bus.spi_ss      = 1'b1;
    bus.spi_sck     = 1'b0;
    bus.spi_mosi    = 1'b1;
    bus.tx_data     = 8'h00;
    bus.tx_data_vld = 1'b0;
    bus.overrun_clr = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_miso",     bus.spi_miso,    1);
    check("rst_tx_ready", bus.tx_ready,    1);
    check("rst_rx_data",  bus.rx_data,     0);
    check("rst_rx_vld",   bus.rx_data_vld, 0);
    check("rst_overrun",  bus.rx_overrun,  0);
    check("rst_selected", bus.selected,    0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: single byte A5, nothing queued -> FF on miso; latency of rx_data_vld
    exp_rx.push_back(8'hA5);
    exp_miso.push_back(8'hFF);
    ss_low();
    check("selected_hi", bus.selected, 1);
    xfer_bits(8'hA5, 7);
    bit_rise(1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rx_data_vld && n < HALF - 1);
    // clk edges until a synchronous consumer sees rx_data_vld high
    check("rx_vld_latency", n + 1, SYNC + 2);
    repeat (HALF - n) @(negedge clk);
    bus.spi_sck = 1'b0;
    ss_high();
    check("t1_tx_ready", bus.tx_ready, 1);
    check("selected_lo", bus.selected, 0);
    check("t1_miso_idle", bus.spi_miso, 1);

    // 2: preloaded 3C, two acked bytes
    tx_write(8'h3C);
    check("t2_tx_ready_full", bus.tx_ready, 0);
    exp_rx.push_back(8'h01);   exp_rx.push_back(8'h02);
    exp_miso.push_back(8'h3C); exp_miso.push_back(8'hFF);
    ss_low();
    check("t2_tx_ready_drained", bus.tx_ready, 1);
    xfer(8'h01);
    xfer(8'h02);
    ss_high();
    repeat (4) @(negedge clk);
    check("t2_overrun", bus.rx_overrun, 0);
    check("t2_rx_vld",  bus.rx_data_vld, 0);

    // 3: two bytes without ack -> overrun, then clear
    ack_en = 1'b0;
    exp_rx.push_back(8'h96);   exp_rx.push_back(8'h69);
    exp_miso.push_back(8'hFF); exp_miso.push_back(8'hFF);
    ss_low();
    xfer(8'h96);
    xfer(8'h69);
    ss_high();
    check("t3_overrun",  bus.rx_overrun, 1);
    check("t3_rx_data",  bus.rx_data, 8'h69);
    check("t3_rx_vld",   bus.rx_data_vld, 1);
    @(negedge clk);
    bus.overrun_clr = 1'b1;
    @(negedge clk);
    bus.overrun_clr = 1'b0;
    check("t3_overrun_clr", bus.rx_overrun, 0);
    ack_en = 1'b1;
    repeat (4) @(negedge clk);
    check("t3_rx_vld_acked", bus.rx_data_vld, 0);

    // 4: aborted partial byte, then C3 must align
    ss_low();
    xfer_bits(8'hB7, 5);
    ss_high();
    check("t4_abort_rx_vld", bus.rx_data_vld, 0);
    check("t4_abort_miso",   bus.spi_miso, 1);
    exp_rx.push_back(8'hC3);
    exp_miso.push_back(8'hFF);
    ss_low();
    xfer(8'hC3);
    ss_high();
    repeat (4) @(negedge clk);

    // 5: write while full ignored; write coincident with reload retained
    tx_write(8'h11);
    tx_write(8'h22);
    check("t5_tx_ready_full", bus.tx_ready, 0);
    exp_rx.push_back(8'h10);   exp_rx.push_back(8'h20);   exp_rx.push_back(8'h30);
    exp_miso.push_back(8'h11); exp_miso.push_back(8'h44); exp_miso.push_back(8'h77);
    ss_low();
    tx_write(8'h44);
    xfer_bits(8'h10, 7);
    bit_rise(1'b0);
    repeat (SYNC) @(negedge clk);
    bus.tx_data     = 8'h77;
    bus.tx_data_vld = 1'b1;
    @(negedge clk);
    bus.tx_data_vld = 1'b0;
    check("t5_tx_ready_coincident", bus.tx_ready, 0);
    repeat (HALF - SYNC - 1) @(negedge clk);
    bus.spi_sck = 1'b0;
    xfer(8'h20);
    xfer(8'h30);
    ss_high();
    repeat (4) @(negedge clk);
    check("t5_tx_ready_empty", bus.tx_ready, 1);

    // 6: async reset mid-byte with non-reset state everywhere
    ack_en = 1'b0;
    exp_rx.push_back(8'h81);   exp_rx.push_back(8'h18);
    exp_miso.push_back(8'hFF); exp_miso.push_back(8'hE7);
    ss_low();
    tx_write(8'hE7);
    xfer(8'h81);
    tx_write(8'h25);
    xfer(8'h18);
    tx_write(8'h55);
    xfer_bits(8'h00, 4);
    repeat (4) @(negedge clk);
    check("t6_pre_miso",     bus.spi_miso,   0);
    check("t6_pre_tx_ready", bus.tx_ready,   0);
    check("t6_pre_overrun",  bus.rx_overrun, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t6_rst_miso",     bus.spi_miso,    1);
    check("t6_rst_tx_ready", bus.tx_ready,    1);
    check("t6_rst_rx_data",  bus.rx_data,     0);
    check("t6_rst_rx_vld",   bus.rx_data_vld, 0);
    check("t6_rst_overrun",  bus.rx_overrun,  0);
    check("t6_rst_selected", bus.selected,    0);
    @(negedge clk);
    bus.spi_ss = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    ack_en  = 1'b1;
    repeat (3) @(negedge clk);
    exp_rx.push_back(8'h5A);
    exp_miso.push_back(8'hFF);
    ss_low();
    xfer(8'h5A);
    ss_high();
    repeat (4) @(negedge clk);
    check("t6_rx_data_after", bus.rx_data, 8'h5A);

    repeat (10) @(negedge clk);
    check("rx_queue_drained",   exp_rx.size(),   0);
    check("miso_queue_drained", exp_miso.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ck1_spi_target.md
Name: ck1_spi_target

Overview:
- SPI mode-0 target (peripheral) that forms the far end of the tk1_spi_master link.
- Used as an on-board responder for SPI master bring-up and loopback, and as a host-facing SPI port.
- Oversamples the asynchronous SPI pins in the system clock domain.
- Exposes byte-level RX/TX handshakes toward a register front-end with the same cs/we/address style as ck1.

Parameters:
- SYNC_STAGES, 2, number of flip-flop synchronizer stages on spi_ss, spi_sck and spi_mosi (legal range 2..3).
- IDLE_FILL, 8'hff, byte shifted out on spi_miso when no TX byte is pending at a byte boundary.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous and active-low.
- spi_ss  in  1  target select, active-low, asynchronous to clk.
- spi_sck  in  1  SPI clock, idle low (mode 0), asynchronous to clk.
- spi_mosi  in  1  master-to-target data, MSB first.
- spi_miso  out  1  target-to-master data, MSB first.
- tx_data  in  8  next byte to transmit.
- tx_data_vld  in  1  one-cycle write strobe that loads tx_data into the TX holding register.
- tx_ready  out  1  high when the TX holding register is empty.
- rx_data  out  8  last completely received byte.
- rx_data_vld  out  1  high while rx_data holds an unconsumed byte.
- rx_ack  in  1  one-cycle strobe that consumes rx_data.
- rx_overrun  out  1  sticky flag: a byte completed while rx_data_vld was high.
- overrun_clr  in  1  clears rx_overrun.
- selected  out  1  synchronized select state (high while the target is selected).

Behaviour:
- Reset values:
  - spi_miso=1, tx_ready=1, rx_data=8'h00, rx_data_vld=0, rx_overrun=0, selected=0.
  - All synchronizer stages reset to the pin idle levels (ss=1, sck=0, mosi=1).
  - Bit counter and shift registers reset to 0; TX shift register resets to IDLE_FILL.
- Synchronization and edge detection:
  - Each pin passes through SYNC_STAGES flops, followed by one history flop.
  - An edge is detected in the cycle where synced != history.
  - Pin-to-detect latency is SYNC_STAGES+1 clk.
- Timing requirement: f_sck ≤ f_clk/8 and SS setup ≥ 4 clk before the first SCK edge. Faster SCK is out of scope and its behaviour is undefined.
- State machine with two states, IDLE and ACTIVE:
  - IDLE -> ACTIVE on a detected ss fall.
    - bit_cnt is cleared to 0.
    - The TX shift register loads the holding byte if the holding register is full, otherwise IDLE_FILL. A full holding register empties (tx_ready rises the next cycle).
  - ACTIVE -> IDLE on a detected ss rise.
    - A partial byte is discarded and rx_data_vld is not raised.
    - bit_cnt is cleared and spi_miso returns to 1 the next cycle.
    - The holding register keeps its contents.
  - ss rise takes priority over any same-cycle sck edge.
- Receive path (rising sck edge detected while ACTIVE):
  - rx_shift <= {rx_shift[6:0], mosi_synced}; bit_cnt <= bit_cnt+1, wrapping from 7 to 0.
  - On the 8th rising edge (bit_cnt==7):
    - The next cycle, rx_data <= completed byte and rx_data_vld <= 1.
    - If rx_data_vld was already 1 and rx_ack is not asserted in that cycle, rx_overrun <= 1; rx_data is still overwritten.
    - In the same cycle the TX shift register reloads as on ss fall, so the next byte's MSB appears on spi_miso.
- Transmit path:
  - spi_miso = tx_shift[7] while ACTIVE.
  - A falling sck edge detected with bit_cnt != 0 shifts tx_shift left, filling with 1.
  - A falling edge with bit_cnt == 0 (byte boundary) does not shift.
- Handshakes:
  - tx_data_vld with tx_ready=0 is ignored; the holding register is not overwritten.
  - tx_data_vld in the same cycle as a reload: the old holding byte is consumed and the new byte is stored, so tx_ready stays 0.
  - rx_ack clears rx_data_vld the next cycle. When rx_ack coincides with byte completion, rx_data_vld stays 1 with the new byte and no overrun is flagged.
  - overrun_clr clears rx_overrun. A simultaneous overrun set takes priority.
- Sck edges while IDLE are ignored.
- Asynchronous reset asserted mid-transfer returns every register to its reset value immediately.

Decomposition:
- A shared package ck1_spi_pkg holds:
  - the mode-0 constants;
  - IDLE_FILL default 8'hff;
  - the state encoding (IDLE=1'b0, ACTIVE=1'b1);
  - a bit-counter width constant of 3.
- One sub-module, ck1_spi_sync: a parameterised SYNC_STAGES-deep synchronizer plus history flop, with rise/fall pulse outputs. Instantiated three times.

Test Plan:
- Reset, then transfer 1 byte, MOSI=8'hA5, no TX loaded -> master samples 8'hFF on MISO; rx_data=8'hA5; rx_data_vld=1 exactly SYNC_STAGES+2 clk after the 8th sck rise; tx_ready=1 throughout.
- Load tx_data=8'h3C before ss fall, then transfer 2 bytes with MOSI 8'h01 and 8'h02, acking each -> MISO yields 8'h3C then 8'hFF; rx_data sequence 8'h01, 8'h02; rx_overrun=0.
- Transfer 2 bytes without rx_ack -> rx_data=second byte, rx_overrun=1; overrun_clr -> rx_overrun=0 next cycle.
- ss deasserted after 5 sck rises -> rx_data_vld stays 0; spi_miso=1; next full byte 8'hC3 is received correctly, proving bit_cnt was cleared.
- tx_data_vld=8'h11 then 8'h22 while tx_ready=0 -> 8'h11 transmitted, 8'h22 ignored; reload coincident with tx_data_vld=8'h77 -> 8'h77 sent in the following byte.
- reset_n asserted low mid-byte -> all outputs at reset values with no clk edge required; normal byte 8'h5A received after release.
